// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage RISC-V core.
// Drives PC / pipeline-register write enables and flushes, inserts load-use
// bubbles, squashes wrong-path instructions and freezes on data-memory waits.
// A memory-wait watchdog latches a sticky bus error.
// Optional feature: define HAZARD_PERF_EN to build the saturating stall-cycle
// performance counter on oStallCycles; otherwise oStallCycles is tied to 0.
module hazard_ctrl #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int MEM_TIMEOUT      = 255
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [4:0]  iIdRs1,
    input  logic [4:0]  iIdRs2,
    input  logic        iIdUsesRs1,
    input  logic        iIdUsesRs2,
    input  logic [4:0]  iExRd,
    input  logic        iExMemRead,
    input  logic        iBranchTaken,
    input  logic        iJump,
    input  logic        iDmemReq,
    input  logic        iDmemReady,
    output logic        oPcWrite,
    output logic        oIfIdWrite,
    output logic        oIdExWrite,
    output logic        oExMemWrite,
    output logic        oIfIdFlush,
    output logic        oIdExFlush,
    output logic        oMemWbFlush,
    output logic [1:0]  oState,
    output logic        oBusErr,
    output logic [31:0] oStallCycles
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  bub_cnt_reg, bub_cnt_next;
    logic [15:0] tmo_cnt_reg, tmo_cnt_next;
    logic        bus_err_reg, bus_err_next;

    logic hazard, redirect, mem_stall;
    logic pc_write, ifid_write, idex_write, exmem_write;
    logic ifid_flush, idex_flush, memwb_flush;

    assign hazard    = iExMemRead && (iExRd != 5'd0) &&
                       ((iIdUsesRs1 && (iIdRs1 == iExRd)) ||
                        (iIdUsesRs2 && (iIdRs2 == iExRd)));
    assign redirect  = iBranchTaken || iJump;
    assign mem_stall = iDmemReq && !iDmemReady;

    // Mealy output decode and next-state / counter computation
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        exmem_write  = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_flush  = 1'b0;
        state_next   = state_reg;
        bub_cnt_next = bub_cnt_reg;
        tmo_cnt_next = tmo_cnt_reg;
        bus_err_next = bus_err_reg;
        case (state_reg)
            ST_RUN: begin
                if (mem_stall) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_write  = 1'b0;
                    memwb_flush  = 1'b1;
                    state_next   = ST_MEM_WAIT;
                    tmo_cnt_next = 16'd1;
                end else if (redirect) begin
                    // ID holds a wrong-path instruction, so any hazard it shows is moot
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (hazard) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    if (LOAD_USE_BUBBLES > 1) begin
                        state_next   = ST_LU_STALL;
                        bub_cnt_next = 3'(LOAD_USE_BUBBLES - 1);
                    end
                end
            end
            ST_LU_STALL: begin
                if (mem_stall) begin
                    // remaining bubbles are discarded; the memory wait dominates
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_write  = 1'b0;
                    memwb_flush  = 1'b1;
                    state_next   = ST_MEM_WAIT;
                    tmo_cnt_next = 16'd1;
                    bub_cnt_next = 3'd0;
                end else begin
                    // EX holds a bubble here, so redirect/hazard inputs are ignored
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_flush   = 1'b1;
                    bub_cnt_next = bub_cnt_reg - 3'd1;
                    if (bub_cnt_reg <= 3'd1) begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (iDmemReady) begin
                    state_next   = ST_RUN;
                    tmo_cnt_next = 16'd0;
                end else begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_write  = 1'b0;
                    exmem_write = 1'b0;
                    memwb_flush = 1'b1;
                    if (tmo_cnt_reg == 16'(MEM_TIMEOUT)) begin
                        state_next   = ST_ERROR;
                        bus_err_next = 1'b1;
                    end else begin
                        tmo_cnt_next = tmo_cnt_reg + 16'd1;
                    end
                end
            end
            default: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_write = 1'b0;
            end
        endcase
    end

    // State, counters and sticky error flag
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_reg   <= ST_RUN;
            bub_cnt_reg <= 3'd0;
            tmo_cnt_reg <= 16'd0;
            bus_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bub_cnt_reg <= bub_cnt_next;
            tmo_cnt_reg <= tmo_cnt_next;
            bus_err_reg <= bus_err_next;
        end
    end

    // While reset is held every enable and flush is forced low
    always_comb begin
        oPcWrite    = pc_write    && !iRST;
        oIfIdWrite  = ifid_write  && !iRST;
        oIdExWrite  = idex_write  && !iRST;
        oExMemWrite = exmem_write && !iRST;
        oIfIdFlush  = ifid_flush  && !iRST;
        oIdExFlush  = idex_flush  && !iRST;
        oMemWbFlush = memwb_flush && !iRST;
    end

    assign oState  = state_reg;
    assign oBusErr = bus_err_reg;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_reg;

    // Count every cycle in which the PC is held; saturate instead of wrapping
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            stall_cnt_reg <= 32'd0;
        end else if (!pc_write && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign oStallCycles = stall_cnt_reg;
`else
    assign oStallCycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (LOAD_USE_BUBBLES=3, MEM_TIMEOUT=8).
module tb_hazard_ctrl;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [4:0]  iIdRs1, iIdRs2, iExRd;
    logic        iIdUsesRs1, iIdUsesRs2, iExMemRead;
    logic        iBranchTaken, iJump, iDmemReq, iDmemReady;
    logic        oPcWrite, oIfIdWrite, oIdExWrite, oExMemWrite;
    logic        oIfIdFlush, oIdExFlush, oMemWbFlush;
    logic [1:0]  oState;
    logic        oBusErr;
    logic [31:0] oStallCycles;

    int total = 0;
    int bad   = 0;
    int model_stall = 0;

    // {pc, ifid, idex, exmem, ifid_fl, idex_fl, memwb_fl, state[1:0], buserr}
    localparam logic [9:0] V_RST   = 10'b0000_000_00_0;
    localparam logic [9:0] V_RUN   = 10'b1111_000_00_0;
    localparam logic [9:0] V_FLUSH = 10'b1111_110_00_0;
    localparam logic [9:0] V_HAZ0  = 10'b0011_010_00_0;
    localparam logic [9:0] V_HAZ1  = 10'b0011_010_01_0;
    localparam logic [9:0] V_FRZ0  = 10'b0000_001_00_0;
    localparam logic [9:0] V_FRZ1  = 10'b0000_001_01_0;
    localparam logic [9:0] V_FRZ2  = 10'b0000_001_10_0;
    localparam logic [9:0] V_RDY2  = 10'b1111_000_10_0;
    localparam logic [9:0] V_ERR   = 10'b0000_000_11_1;

    logic [9:0] obs;
    assign obs = {oPcWrite, oIfIdWrite, oIdExWrite, oExMemWrite,
                  oIfIdFlush, oIdExFlush, oMemWbFlush, oState, oBusErr};

    hazard_ctrl #(.LOAD_USE_BUBBLES(3), .MEM_TIMEOUT(8)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iIdRs1(iIdRs1), .iIdRs2(iIdRs2),
        .iIdUsesRs1(iIdUsesRs1), .iIdUsesRs2(iIdUsesRs2),
        .iExRd(iExRd), .iExMemRead(iExMemRead),
        .iBranchTaken(iBranchTaken), .iJump(iJump),
        .iDmemReq(iDmemReq), .iDmemReady(iDmemReady),
        .oPcWrite(oPcWrite), .oIfIdWrite(oIfIdWrite),
        .oIdExWrite(oIdExWrite), .oExMemWrite(oExMemWrite),
        .oIfIdFlush(oIfIdFlush), .oIdExFlush(oIdExFlush),
        .oMemWbFlush(oMemWbFlush), .oState(oState),
        .oBusErr(oBusErr), .oStallCycles(oStallCycles)
    );

    always #5 iCLK = ~iCLK;

    function automatic int exp_perf();
`ifdef HAZARD_PERF_EN
        return model_stall;
`else
        return 0;
`endif
    endfunction

    // Called at posedge+1 with inputs already set; checks at posedge+4,
    // then advances to the next posedge+1.
    task automatic chk(input string tag, input logic [9:0] exp);
        #3;
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: outputs got %b want %b", tag, obs, exp);
        end
        total++;
        assert (oStallCycles === 32'(exp_perf())) else begin
            bad++;
            $error("FAIL %s_perf: stall count got %0d want %0d", tag, oStallCycles, exp_perf());
        end
        $display("step %-14s obs=%b exp=%b stall=%0d", tag, obs, exp, oStallCycles);
        if (!exp[9] && !iRST) model_stall++;
        @(posedge iCLK);
        #1;
    endtask

    task automatic clear_inputs();
        iIdRs1 = 5'd0; iIdRs2 = 5'd0; iExRd = 5'd0;
        iIdUsesRs1 = 1'b0; iIdUsesRs2 = 1'b0; iExMemRead = 1'b0;
        iBranchTaken = 1'b0; iJump = 1'b0; iDmemReq = 1'b0; iDmemReady = 1'b0;
    endtask

    initial begin
        iRST = 1'b1;
        clear_inputs();
        // reset state
        chk("reset", V_RST);
        iRST = 1'b0;
        chk("idle", V_RUN);

        // load to x0 never creates a hazard
        iExMemRead = 1'b1; iExRd = 5'd0; iIdRs1 = 5'd0; iIdUsesRs1 = 1'b1;
        chk("lu_x0", V_RUN);

        // load-use on rs2=x7: three stall cycles, LU_STALL in cycles 2..3;
        // a taken branch during LU_STALL is ignored
        clear_inputs();
        iExMemRead = 1'b1; iExRd = 5'd7; iIdRs2 = 5'd7; iIdUsesRs2 = 1'b1;
        chk("lu_x7_c1", V_HAZ0);
        iBranchTaken = 1'b1;
        chk("lu_x7_c2", V_HAZ1);
        iBranchTaken = 1'b0;
        chk("lu_x7_c3", V_HAZ1);
        clear_inputs();
        chk("lu_x7_done", V_RUN);

        // rs2 matches but is not used: no hazard
        iExMemRead = 1'b1; iExRd = 5'd7; iIdRs2 = 5'd7; iIdUsesRs2 = 1'b0;
        chk("lu_unused", V_RUN);

        // branch taken together with a hazard: redirect wins, no stall
        clear_inputs();
        iExMemRead = 1'b1; iExRd = 5'd9; iIdRs1 = 5'd9; iIdUsesRs1 = 1'b1;
        iBranchTaken = 1'b1;
        chk("br_haz", V_FLUSH);
        clear_inputs();
        chk("br_haz_after", V_RUN);

        // jal alone
        iJump = 1'b1;
        chk("jump", V_FLUSH);
        clear_inputs();

        // ready without request in RUN is ignored
        iDmemReady = 1'b1;
        chk("rdy_noreq", V_RUN);
        clear_inputs();

        // memory wait: ready low 4 cycles then high; jal held in EX is
        // only acted on the cycle after the ready
        iDmemReq = 1'b1;
        chk("mw_c0", V_FRZ0);
        for (int i = 1; i <= 3; i++) chk($sformatf("mw_c%0d", i), V_FRZ2);
        iDmemReady = 1'b1; iJump = 1'b1;
        chk("mw_ready", V_RDY2);
        iDmemReq = 1'b0; iDmemReady = 1'b0;
        chk("mw_redirect", V_FLUSH);
        clear_inputs();
        chk("mw_done", V_RUN);

        // load-use on rs1=x5 interrupted by a memory stall: bubbles discarded
        iExMemRead = 1'b1; iExRd = 5'd5; iIdRs1 = 5'd5; iIdUsesRs1 = 1'b1;
        chk("lum_haz", V_HAZ0);
        iDmemReq = 1'b1;
        chk("lum_stall", V_FRZ1);
        iDmemReady = 1'b1;
        chk("lum_ready", V_RDY2);
        clear_inputs();
        chk("lum_run", V_RUN);

        // watchdog: ready never comes, ERROR after 8 MEM_WAIT cycles
        iDmemReq = 1'b1;
        chk("to_c0", V_FRZ0);
        for (int i = 1; i <= 8; i++) chk($sformatf("to_wait%0d", i), V_FRZ2);
        chk("to_err1", V_ERR);
        iDmemReady = 1'b1;
        chk("to_err_rdy", V_ERR);
        clear_inputs();
        chk("to_err_held", V_ERR);

        // asynchronous reset in ERROR, checked before any clock edge
        iRST = 1'b1;
        #1;
        total++;
        assert (obs === V_RST) else begin
            bad++;
            $error("FAIL async_rst: outputs got %b want %b", obs, V_RST);
        end
        total++;
        assert (oStallCycles === 32'd0) else begin
            bad++;
            $error("FAIL async_rst_perf: stall count got %0d want 0", oStallCycles);
        end
        $display("step %-14s obs=%b exp=%b stall=%0d", "async_rst", obs, V_RST, oStallCycles);
        model_stall = 0;
        #2;
        chk("rst_hold", V_RST);
        iRST = 1'b0;
        chk("post_rst", V_RUN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
